dcache_assoc: RTL
=================

DCACHE_ASSOC -- requirements
Module: dcache_assoc

Interface
REQ-001 SHALL have parameter ADDRBITS, default 32, meaning address width; data width is fixed at 32.
REQ-002 SHALL have parameter LINEBITS, default 3, meaning log2 of words per line (8 words = 32 bytes).
REQ-003 SHALL have parameter SETBITS, default 4, meaning log2 of sets; ways are fixed at 2.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have CPU ports: dcache_addr in ADDRBITS; dcache_in in 32; dcache_out out 32; dcache_out_valid out 1; dcache_rdreq in 1; dcache_wrreq in 1; dcache_wordlen in 2 (0=byte, 1=half, 2/3=word); dcache_unsigned in 1 (1=zero-extend loads).
REQ-007 SHALL have dcache_ready, output, 1 (1=request accepted this cycle); and dcache_flush, input, 1 (write back all dirty lines).
REQ-008 SHALL have memory ports: mem_addr out ADDRBITS (byte address); mem_in out 32 (write data); mem_out in 32; mem_out_valid in 1; mem_rdreq out 1; mem_wrreq out 1; mem_burstlen out 16.

Function
REQ-009 SHALL decode address as offset addr[LINEBITS+1:0], set addr[LINEBITS+SETBITS+1:LINEBITS+2], tag the remaining upper bits.
REQ-010 SHALL keep per way/set: valid, dirty, tag; per set: one LRU bit naming the victim way.
REQ-011 SHALL accept a request only on an edge where dcache_ready=1; requests while ready=0 are ignored, not queued.
REQ-012 SHALL give wrreq priority when rdreq and wrreq are both high; rdreq is dropped.
REQ-013 Read hit: dcache_out_valid=1 for exactly one cycle, the cycle after acceptance; ready stays 1 (back-to-back hits every cycle).
REQ-014 Write hit: merge byte lanes (little-endian; byte lane addr[1:0], half lane addr[1], addr[0] ignored for half, addr[1:0] ignored for word), set dirty, no dcache_out_valid, ready stays 1.
REQ-015 Loads: byte/half sign-extended unless dcache_unsigned=1; a read of an address written the previous cycle returns the new data.
REQ-016 Every hit and fill completion SHALL make the accessed way MRU (LRU bit points to the other way).
REQ-017 FSM states: IDLE, WRITEBACK, FILL_REQ, FILL_WAIT, REPLAY, FLUSH; ready=1 only in IDLE.
REQ-018 Miss: latch request; victim = invalid way if any (way 0 first), else LRU way; victim dirty -> WRITEBACK, else FILL_REQ.
REQ-019 WRITEBACK: 2^LINEBITS consecutive cycles, mem_wrreq=1, mem_burstlen=1, mem_addr = victim line base + 4*i, mem_in = word i; memory has no backpressure.
REQ-020 FILL_REQ: one cycle mem_rdreq=1, mem_addr = line base, mem_burstlen=2^LINEBITS; then FILL_WAIT stores one word per mem_out_valid cycle (gaps allowed) until 2^LINEBITS words, sets valid, clears dirty, writes tag.
REQ-021 REPLAY: complete the latched request exactly as a hit (REQ-013/014), then IDLE.
REQ-022 dcache_flush SHALL set a pending flag; it starts from IDLE when no request is accepted that cycle; a request in the same cycle is served first.
REQ-023 FLUSH: visit every set/way in order; dirty lines written back per REQ-019 and dirty cleared; valid and LRU kept; clean lines cost one cycle; IDLE afterwards.
REQ-024 mem_rdreq and mem_wrreq SHALL never be high together; mem_burstlen=1 whenever not in FILL_REQ.

Reset
REQ-025 While reset_n=0: FSM IDLE, all valid/dirty/LRU bits 0, flush pending 0, dcache_out_valid=0, dcache_ready=1, mem_rdreq=0, mem_wrreq=0, mem_addr=0, mem_in=0, mem_burstlen=1, dcache_out=0; data array not cleared.
REQ-026 Reset asserted mid-WRITEBACK/FILL SHALL abort at once; partially filled line stays invalid; late mem_out_valid after release is ignored in IDLE.

Verification (LINEBITS=3, SETBITS=2, memory pre-zeroed, mem_out_valid = mem_rdreq delayed one cycle per word)
REQ-027 Write 0x0fff0001..0x0fff0008 to 0x080..0x09c back-to-back -> one fill at 0x080 burstlen 8, then reads of 0x080..0x09c return same values, one per cycle, no mem traffic.
REQ-028 Write 0x11111111@0x000, 0x22222222@0x080 (same set), read 0x000, write 0x33333333@0x100 -> 8 mem_wrreq from 0x080, first mem_in 0x22222222; re-read 0x000 hits with 0x11111111.
REQ-029 Byte write 0x80 to 0x203 -> signed byte read 0xffffff80, unsigned 0x00000080, word read 0x80000000; half write 0x8001 to 0x206 -> signed half read 0xffff8001.
REQ-030 Two dirty lines then dcache_flush -> exactly 16 mem_wrreq cycles, ready low until done; second flush -> zero mem_wrreq; reads then hit.
REQ-031 reset_n low during FILL_WAIT -> mem_rdreq=0, ready=1 immediately; subsequent read of previously cached 0x000 misses and refills.

Source files
------------

// File: rtl/dcache_assoc.sv
// Two-way set-associative write-back data cache with per-set LRU,
// critical-path-free burst fill, dirty-line writeback and full flush.
module dcache_assoc #(
    parameter int ADDRBITS = 32,
    parameter int LINEBITS = 3,
    parameter int SETBITS  = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDRBITS-1:0] dcache_addr,
    input  logic [31:0]         dcache_in,
    output logic [31:0]         dcache_out,
    output logic                dcache_out_valid,
    input  logic                dcache_rdreq,
    input  logic                dcache_wrreq,
    input  logic [1:0]          dcache_wordlen,
    input  logic                dcache_unsigned,
    output logic                dcache_ready,
    input  logic                dcache_flush,
    output logic [ADDRBITS-1:0] mem_addr,
    output logic [31:0]         mem_in,
    input  logic [31:0]         mem_out,
    input  logic                mem_out_valid,
    output logic                mem_rdreq,
    output logic                mem_wrreq,
    output logic [15:0]         mem_burstlen
);
    localparam int WORDS  = 1 << LINEBITS;
    localparam int SETS   = 1 << SETBITS;
    localparam int TAGW   = ADDRBITS - LINEBITS - SETBITS - 2;
    localparam int TAG_LO = LINEBITS + SETBITS + 2;
    localparam logic [LINEBITS-1:0] WORD_LAST = '1;
    localparam logic [SETBITS:0]    FL_LAST   = '1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WRITEBACK = 3'd1;
    localparam logic [2:0] S_FILL_REQ  = 3'd2;
    localparam logic [2:0] S_FILL_WAIT = 3'd3;
    localparam logic [2:0] S_REPLAY    = 3'd4;
    localparam logic [2:0] S_FLUSH     = 3'd5;

    // Insert a byte/half/word store into the existing little-endian word.
    function automatic logic [31:0] merge_store(input logic [31:0] old, input logic [31:0] wdata,
                                                input logic [1:0] len, input logic [1:0] off);
        logic [31:0] mask;
        logic [31:0] data;
        case (len)
            2'd0: begin
                mask = 32'h0000_00ff << {off, 3'b000};
                data = {4{wdata[7:0]}};
            end
            2'd1: begin
                mask = 32'h0000_ffff << {off[1], 4'b0000};
                data = {2{wdata[15:0]}};
            end
            default: begin
                mask = 32'hffff_ffff;
                data = wdata;
            end
        endcase
        return (old & ~mask) | (data & mask);
    endfunction

    // Extract the addressed byte/half and sign- or zero-extend it.
    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] len,
                                             input logic [1:0] off, input logic uns);
        logic [31:0] sh;
        logic [31:0] res;
        case (len)
            2'd0: begin
                sh  = word >> {off, 3'b000};
                res = {{24{sh[7] & ~uns}}, sh[7:0]};
            end
            2'd1: begin
                sh  = word >> {off[1], 4'b0000};
                res = {{16{sh[15] & ~uns}}, sh[15:0]};
            end
            default: begin
                sh  = word;
                res = sh;
            end
        endcase
        return res;
    endfunction

    logic [2:0]          state;
    logic [SETS-1:0]     valid [2];
    logic [SETS-1:0]     dirty [2];
    logic [SETS-1:0]     lru;
    logic                flush_pend;
    logic                vway;
    logic [LINEBITS-1:0] wcnt;
    logic [SETBITS:0]    fl_idx;

    logic [TAGW-1:0]     tag_mem  [2][SETS];
    logic [31:0]         data_mem [2][SETS][WORDS];

    logic [ADDRBITS-1:0] req_addr;
    logic [31:0]         req_wdata;
    logic                req_wr;
    logic [1:0]          req_len;
    logic                req_uns;

    logic [ADDRBITS-1:0] cur_addr;
    logic [31:0]         cur_wdata;
    logic [1:0]          cur_len;
    logic                cur_uns, cur_wr, cur_rd;

    logic [SETBITS-1:0]  cur_set, req_set, fl_set;
    logic [TAGW-1:0]     cur_tag, req_tag;
    logic [LINEBITS-1:0] cur_word;
    logic                fl_way, fl_dirty;
    logic                hit0, hit1, hit, hit_way, victim, do_access, miss;
    logic [31:0]         hit_word;

    // In REPLAY the latched request is served through the same hit path as a live one.
    always_comb begin
        if (state == S_REPLAY) begin
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
            cur_len   = req_len;
            cur_uns   = req_uns;
            cur_wr    = req_wr;
            cur_rd    = ~req_wr;
        end else begin
            cur_addr  = dcache_addr;
            cur_wdata = dcache_in;
            cur_len   = dcache_wordlen;
            cur_uns   = dcache_unsigned;
            cur_wr    = (state == S_IDLE) & dcache_wrreq;
            cur_rd    = (state == S_IDLE) & dcache_rdreq & ~dcache_wrreq;
        end
    end

    assign cur_set   = cur_addr[TAG_LO-1:LINEBITS+2];
    assign cur_tag   = cur_addr[ADDRBITS-1:TAG_LO];
    assign cur_word  = cur_addr[LINEBITS+1:2];
    assign req_set   = req_addr[TAG_LO-1:LINEBITS+2];
    assign req_tag   = req_addr[ADDRBITS-1:TAG_LO];
    assign fl_set    = fl_idx[SETBITS:1];
    assign fl_way    = fl_idx[0];
    assign fl_dirty  = dirty[fl_way][fl_set];

    assign hit0      = valid[0][cur_set] && (tag_mem[0][cur_set] == cur_tag);
    assign hit1      = valid[1][cur_set] && (tag_mem[1][cur_set] == cur_tag);
    assign hit       = hit0 | hit1;
    assign hit_way   = ~hit0;
    assign hit_word  = data_mem[hit_way][cur_set][cur_word];
    assign do_access = (cur_wr | cur_rd) & hit;
    assign miss      = (state == S_IDLE) & (cur_wr | cur_rd) & ~hit;
    assign victim    = !valid[0][cur_set] ? 1'b0 : (!valid[1][cur_set] ? 1'b1 : lru[cur_set]);

    assign dcache_ready = (state == S_IDLE);

    // Memory-side request decode; idle outputs are all zero with single-word burst length.
    always_comb begin
        mem_addr     = '0;
        mem_in       = '0;
        mem_rdreq    = 1'b0;
        mem_wrreq    = 1'b0;
        mem_burstlen = 16'd1;
        case (state)
            S_WRITEBACK: begin
                mem_wrreq = 1'b1;
                mem_addr  = {tag_mem[vway][req_set], req_set, wcnt, 2'b00};
                mem_in    = data_mem[vway][req_set][wcnt];
            end
            S_FILL_REQ: begin
                mem_rdreq    = 1'b1;
                mem_addr     = {req_tag, req_set, {LINEBITS{1'b0}}, 2'b00};
                mem_burstlen = 16'(WORDS);
            end
            S_FLUSH: begin
                if (fl_dirty) begin
                    mem_wrreq = 1'b1;
                    mem_addr  = {tag_mem[fl_way][fl_set], fl_set, wcnt, 2'b00};
                    mem_in    = data_mem[fl_way][fl_set][wcnt];
                end
            end
            default: ;
        endcase
    end

    // Control FSM, line state bits, LRU and load result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= S_IDLE;
            valid[0]         <= '0;
            valid[1]         <= '0;
            dirty[0]         <= '0;
            dirty[1]         <= '0;
            lru              <= '0;
            flush_pend       <= 1'b0;
            vway             <= 1'b0;
            wcnt             <= '0;
            fl_idx           <= '0;
            dcache_out       <= '0;
            dcache_out_valid <= 1'b0;
        end else begin
            dcache_out_valid <= 1'b0;
            if (dcache_flush) flush_pend <= 1'b1;
            if (do_access) begin
                lru[cur_set] <= ~hit_way;
                if (cur_wr) begin
                    dirty[hit_way][cur_set] <= 1'b1;
                end else begin
                    dcache_out_valid <= 1'b1;
                    dcache_out       <= load_ext(hit_word, cur_len, cur_addr[1:0], cur_uns);
                end
            end
            case (state)
                S_IDLE: begin
                    if (miss) begin
                        vway  <= victim;
                        wcnt  <= '0;
                        state <= dirty[victim][cur_set] ? S_WRITEBACK : S_FILL_REQ;
                    end else if (!do_access && (flush_pend || dcache_flush)) begin
                        flush_pend <= 1'b0;
                        fl_idx     <= '0;
                        wcnt       <= '0;
                        state      <= S_FLUSH;
                    end
                end
                S_WRITEBACK: begin
                    wcnt <= wcnt + 1'b1;
                    if (wcnt == WORD_LAST) begin
                        dirty[vway][req_set] <= 1'b0;
                        state                <= S_FILL_REQ;
                    end
                end
                S_FILL_REQ: begin
                    valid[vway][req_set] <= 1'b0;
                    wcnt                 <= '0;
                    state                <= S_FILL_WAIT;
                end
                S_FILL_WAIT: begin
                    if (mem_out_valid) begin
                        wcnt <= wcnt + 1'b1;
                        if (wcnt == WORD_LAST) begin
                            valid[vway][req_set] <= 1'b1;
                            dirty[vway][req_set] <= 1'b0;
                            lru[req_set]         <= ~vway;
                            state                <= S_REPLAY;
                        end
                    end
                end
                S_REPLAY: state <= S_IDLE;
                S_FLUSH: begin
                    if (fl_dirty) begin
                        wcnt <= wcnt + 1'b1;
                        if (wcnt == WORD_LAST) begin
                            dirty[fl_way][fl_set] <= 1'b0;
                            fl_idx                <= fl_idx + 1'b1;
                            if (fl_idx == FL_LAST) state <= S_IDLE;
                        end
                    end else begin
                        fl_idx <= fl_idx + 1'b1;
                        if (fl_idx == FL_LAST) state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Data/tag arrays and the latched miss request; these carry no reset.
    always_ff @(posedge clk) begin
        if (miss) begin
            req_addr  <= cur_addr;
            req_wdata <= cur_wdata;
            req_wr    <= cur_wr;
            req_len   <= cur_len;
            req_uns   <= cur_uns;
        end
        if (do_access && cur_wr)
            data_mem[hit_way][cur_set][cur_word] <= merge_store(hit_word, cur_wdata, cur_len, cur_addr[1:0]);
        if (state == S_FILL_WAIT && mem_out_valid) begin
            data_mem[vway][req_set][wcnt] <= mem_out;
            if (wcnt == WORD_LAST) tag_mem[vway][req_set] <= req_tag;
        end
    end

endmodule
